// File: rtl/cond_flags_unit.sv
// Architectural NZCV flags register and branch resolver: latches ALU flags on
// flag-setting ops and registers a taken/not-taken decision for fetch.
module cond_flags_unit #(
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 stall,
    input  logic                 flush,
    input  logic                 alu_valid,
    input  logic                 set_flags,
    input  logic                 alu_n,
    input  logic                 alu_z,
    input  logic                 alu_c,
    input  logic                 alu_v,
    input  logic                 br_valid,
    input  logic [1:0]           br_type,
    input  logic [3:0]           cond,
    input  logic                 reg_zero,
    output logic [3:0]           flags_q,
    output logic                 br_out_valid,
    output logic                 br_taken,
    output logic [CNT_WIDTH-1:0] taken_cnt
);

    localparam logic [1:0] BR_B    = 2'b00;
    localparam logic [1:0] BR_CBZ  = 2'b01;
    localparam logic [1:0] BR_CBNZ = 2'b10;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    logic [3:0]           alu_flags;
    logic [3:0]           eff;
    logic                 f_n, f_z, f_c, f_v;
    logic                 base;
    logic                 cond_res;
    logic                 decision;
    logic                 upd;
    logic [3:0]           flags_d;
    logic                 valid_q, valid_d;
    logic                 taken_q, taken_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    // Forward same-cycle flags into the decision; the register follows upd only.
    always_comb begin
        alu_flags = {alu_n, alu_z, alu_c, alu_v};
        eff       = (alu_valid & set_flags) ? alu_flags : flags_q;
        {f_n, f_z, f_c, f_v} = eff;

        // Odd condition codes invert the even base, except the AL pair.
        case (cond[3:1])
            3'b000:  base = f_z;
            3'b001:  base = f_c;
            3'b010:  base = f_n;
            3'b011:  base = f_v;
            3'b100:  base = f_c & ~f_z;
            3'b101:  base = (f_n == f_v);
            3'b110:  base = ~f_z & (f_n == f_v);
            default: base = 1'b1;
        endcase
        cond_res = (cond[3:1] == 3'b111) ? 1'b1 : (base ^ cond[0]);

        case (br_type)
            BR_B:    decision = 1'b1;
            BR_CBZ:  decision = reg_zero;
            BR_CBNZ: decision = ~reg_zero;
            default: decision = cond_res;
        endcase

        upd     = alu_valid & set_flags & ~stall & ~flush;
        flags_d = upd ? alu_flags : flags_q;

        valid_d = valid_q;
        taken_d = taken_q;
        cnt_d   = cnt_q;
        if (flush) begin
            valid_d = 1'b0;
            taken_d = 1'b0;
        end else if (!stall) begin
            valid_d = br_valid;
            taken_d = br_valid & decision;
            if (taken_d && (cnt_q != CNT_MAX)) begin
                cnt_d = cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q <= 4'b0000;
            valid_q <= 1'b0;
            taken_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            flags_q <= flags_d;
            valid_q <= valid_d;
            taken_q <= taken_d;
            cnt_q   <= cnt_d;
        end
    end

    assign br_out_valid = valid_q;
    assign br_taken     = taken_q;
    assign taken_cnt    = cnt_q;

endmodule

// File: tb/tb_cond_flags_unit.sv
// Self-checking bench for cond_flags_unit: scoreboard of expected outputs plus
// a table of hand-computed branch vectors and multi-cycle corner sequences.
module tb_cond_flags_unit;

    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          stall = 1'b0, flush = 1'b0;
    logic          alu_valid = 1'b0, set_flags = 1'b0;
    logic          alu_n = 1'b0, alu_z = 1'b0, alu_c = 1'b0, alu_v = 1'b0;
    logic          br_valid = 1'b0;
    logic [1:0]    br_type = 2'b00;
    logic [3:0]    cond = 4'b0000;
    logic          reg_zero = 1'b0;
    logic [3:0]    flags_q;
    logic          br_out_valid, br_taken;
    logic [CW-1:0] taken_cnt;

    cond_flags_unit #(.CNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .alu_valid(alu_valid), .set_flags(set_flags),
        .alu_n(alu_n), .alu_z(alu_z), .alu_c(alu_c), .alu_v(alu_v),
        .br_valid(br_valid), .br_type(br_type), .cond(cond), .reg_zero(reg_zero),
        .flags_q(flags_q), .br_out_valid(br_out_valid), .br_taken(br_taken),
        .taken_cnt(taken_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          v;
        logic          t;
        logic [3:0]    f;
        logic [CW-1:0] c;
    } exp_t;

    typedef struct {
        logic [3:0] nzcv;
        logic [1:0] bt;
        logic [3:0] cd;
        logic       rz;
        logic       exp_taken;
        string      name;
    } vec_t;

    exp_t          sbq[$];
    int            n_cmp = 0;
    int            n_err = 0;
    logic [3:0]    m_flags = 4'b0000;
    logic [CW-1:0] m_cnt = '0;
    logic          m_v = 1'b0, m_t = 1'b0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference condition table written directly from the A64 definitions.
    function automatic logic cond_ref(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return cy;
            4'd3:  return !cy;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return cy && !z;
            4'd9:  return !(cy && !z);
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return !z && (n == v);
            4'd13: return !(!z && (n == v));
            default: return 1'b1;
        endcase
    endfunction

    // Drive one cycle of stimulus, push the model's expectation, compare after the edge.
    task automatic drive(input logic st, input logic fl, input logic av, input logic sf,
                         input logic [3:0] nzcv, input logic bv, input logic [1:0] bt,
                         input logic [3:0] cd, input logic rz);
        logic [3:0] eff;
        logic       dec;
        exp_t       e;
        exp_t       got;
        stall = st; flush = fl; alu_valid = av; set_flags = sf;
        {alu_n, alu_z, alu_c, alu_v} = nzcv;
        br_valid = bv; br_type = bt; cond = cd; reg_zero = rz;

        eff = (av && sf) ? nzcv : m_flags;
        case (bt)
            2'b00:   dec = 1'b1;
            2'b01:   dec = rz;
            2'b10:   dec = !rz;
            default: dec = cond_ref(cd, eff);
        endcase
        if (fl) begin
            m_v = 1'b0; m_t = 1'b0;
        end else if (!st) begin
            m_v = bv; m_t = bv && dec;
            if (m_t && m_cnt != {CW{1'b1}}) m_cnt = m_cnt + 1'b1;
        end
        if (av && sf && !st && !fl) m_flags = nzcv;
        e.v = m_v; e.t = m_t; e.f = m_flags; e.c = m_cnt;
        sbq.push_back(e);

        @(posedge clk);
        #1;
        got = sbq.pop_front();
        check("br_out_valid", 8'(br_out_valid), 8'(got.v));
        check("br_taken", 8'(br_taken), 8'(got.t));
        check("flags_q", 8'(flags_q), 8'(got.f));
        check("taken_cnt", 8'(taken_cnt), 8'(got.c));
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 2'b00, 4'b0000, 1'b0);
    endtask

    task automatic async_reset_check(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        check({tag, "_valid"}, 8'(br_out_valid), 8'd0);
        check({tag, "_taken"}, 8'(br_taken), 8'd0);
        check({tag, "_flags"}, 8'(flags_q), 8'd0);
        check({tag, "_cnt"}, 8'(taken_cnt), 8'd0);
        m_flags = 4'b0000; m_cnt = '0; m_v = 1'b0; m_t = 1'b0;
        sbq.delete();
        #1;
        rst_n = 1'b1;
    endtask

    vec_t vecs[12];

    initial begin
        vecs[0]  = '{4'b1001, 2'b11, 4'd12, 1'b0, 1'b1, "gt_n1v1"};
        vecs[1]  = '{4'b0100, 2'b11, 4'd13, 1'b0, 1'b1, "le_z1"};
        vecs[2]  = '{4'b0000, 2'b01, 4'd0,  1'b1, 1'b1, "cbz_rz1"};
        vecs[3]  = '{4'b0000, 2'b10, 4'd0,  1'b1, 1'b0, "cbnz_rz1"};
        vecs[4]  = '{4'b0000, 2'b01, 4'd0,  1'b0, 1'b0, "cbz_rz0"};
        vecs[5]  = '{4'b0000, 2'b00, 4'd1,  1'b0, 1'b1, "b_uncond"};
        vecs[6]  = '{4'b0010, 2'b11, 4'd8,  1'b0, 1'b1, "hi_c1z0"};
        vecs[7]  = '{4'b0110, 2'b11, 4'd8,  1'b0, 1'b0, "hi_c1z1"};
        vecs[8]  = '{4'b1000, 2'b11, 4'd11, 1'b0, 1'b1, "lt_n1v0"};
        vecs[9]  = '{4'b0000, 2'b11, 4'd15, 1'b0, 1'b1, "nv_always"};
        vecs[10] = '{4'b0001, 2'b11, 4'd7,  1'b0, 1'b0, "vc_v1"};
        vecs[11] = '{4'b1101, 2'b11, 4'd12, 1'b0, 1'b0, "gt_z1"};

        // Power-on reset state.
        #3;
        check("rst_valid", 8'(br_out_valid), 8'd0);
        check("rst_taken", 8'(br_taken), 8'd0);
        check("rst_flags", 8'(flags_q), 8'd0);
        check("rst_cnt", 8'(taken_cnt), 8'd0);
        #9;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Asynchronous reset while a decision is pending.
        drive(1'b0, 1'b0, 1'b1, 1'b1, 4'b1010, 1'b1, 2'b00, 4'd0, 1'b0);
        check("pre_rst_valid", 8'(br_out_valid), 8'd1);
        async_reset_check("midrst");

        // Flag latch, then non-flag-setting ADD leaves flags unchanged.
        drive(1'b0, 1'b0, 1'b1, 1'b1, 4'b0110, 1'b0, 2'b00, 4'd0, 1'b0);
        check("subs_flags", 8'(flags_q), 8'b0110);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 2'b00, 4'd0, 1'b0);
        check("add_noflags", 8'(flags_q), 8'b0110);

        // Forwarding: B.EQ sees the same-cycle Z; without set_flags it does not.
        drive(1'b0, 1'b0, 1'b1, 1'b1, 4'b0000, 1'b0, 2'b00, 4'd0, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b1, 4'b0100, 1'b1, 2'b11, 4'd0, 1'b0);
        check("fwd_eq_taken", 8'(br_taken), 8'd1);
        drive(1'b0, 1'b0, 1'b1, 1'b1, 4'b0000, 1'b0, 2'b00, 4'd0, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 4'b0100, 1'b1, 2'b11, 4'd0, 1'b0);
        check("nofwd_eq_taken", 8'(br_taken), 8'd0);

        // Hand-computed vectors with forwarded flags.
        foreach (vecs[i]) begin
            drive(1'b0, 1'b0, 1'b1, 1'b1, vecs[i].nzcv, 1'b1, vecs[i].bt, vecs[i].cd, vecs[i].rz);
            check(vecs[i].name, 8'(br_taken), 8'(vecs[i].exp_taken));
        end

        // Full condition sweep, back-to-back via forwarding, then via flags_q.
        for (int c = 0; c < 16; c++) begin
            for (int f = 0; f < 16; f++) begin
                drive(1'b0, 1'b0, 1'b1, 1'b1, 4'(f), 1'b1, 2'b11, 4'(c), 1'b0);
            end
        end
        for (int f = 0; f < 16; f += 5) begin
            drive(1'b0, 1'b0, 1'b1, 1'b1, 4'(f), 1'b0, 2'b00, 4'd0, 1'b0);
            for (int c = 0; c < 16; c++) begin
                drive(1'b0, 1'b0, 1'b0, 1'b1, 4'(~f), 1'b1, 2'b11, 4'(c), 1'b0);
            end
        end

        // No-branch cycles must register not-taken whatever cond/reg_zero say.
        drive(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 2'b01, 4'd14, 1'b1);

        // Stall freezes outputs and blocks the flag update for 3 cycles.
        drive(1'b0, 1'b0, 1'b1, 1'b1, 4'b0010, 1'b1, 2'b00, 4'd0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 1'b0, 1'b1, 1'b1, 4'b1111, 1'b1, 2'b10, 4'd0, 1'b1);
            check("stall_hold_taken", 8'(br_taken), 8'd1);
        end
        check("stall_flags", 8'(flags_q), 8'b0010);

        // Flush over stall: squashes the decision and the same-cycle SUBS.
        drive(1'b1, 1'b1, 1'b1, 1'b1, 4'b1101, 1'b1, 2'b00, 4'd0, 1'b0);
        check("flush_valid", 8'(br_out_valid), 8'd0);
        check("flush_flags", 8'(flags_q), 8'b0010);
        idle();

        // Counter saturation from a fresh reset.
        async_reset_check("satrst");
        for (int k = 1; k <= 17; k++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1, 2'b00, 4'd0, 1'b0);
            check("sat_cnt", 8'(taken_cnt), (k >= 15) ? 8'd15 : 8'(k));
        end
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
